// File: rtl/miso_frame_packer.sv
// miso_frame_packer: deserializes Intan MISO into 16-bit channel words, packs each
// timestep into a timestamped 32-bit frame, and queues frames on an AXI-Stream master.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   SCLK, CS, MISO    SPI signals from the SPI master / headstage (resynchronized)
//   channel           channel index driven during the current CS window
//   timestamp         timestep counter, latched with each CS window
//   clear_errors      one-cycle pulse clearing err_short / err_seq
//   m_tdata/m_tvalid/m_tready/m_tlast   frame word stream (first-word fall-through)
//   frame_count       frames fully written into the FIFO (wraps)
//   drop_count        frames discarded for lack of space (saturating)
//   err_short         sticky: a CS window closed with a bit count other than 16
//   err_seq           sticky: channel sequence broken mid-frame
//
// Build option: define FRAME_MAGIC_EN to prefix every frame with the two
// magic words 0x27021942, 0xC6911999 ahead of the timestamp.

module miso_frame_packer #(
    parameter int NUM_CH      = 35,
    parameter int FIFO_DEPTH  = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        SCLK,
    input  logic        CS,
    input  logic        MISO,
    input  logic [5:0]  channel,
    input  logic [31:0] timestamp,
    input  logic        clear_errors,
    output logic [31:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic [31:0] frame_count,
    output logic [15:0] drop_count,
    output logic        err_short,
    output logic        err_seq
);

`ifdef FRAME_MAGIC_EN
    localparam int HDR_WORDS = 3;
`else
    localparam int HDR_WORDS = 1;
`endif
    localparam int FRAME_WORDS = HDR_WORDS + (NUM_CH + 1) / 2;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] FRAME_C    = CW'(FRAME_WORDS);
    localparam logic [6:0]    FRAME_LAST = 7'(FRAME_WORDS - 1);
    localparam logic [1:0]    HDR_C      = 2'(HDR_WORDS);
    localparam logic [5:0]    LAST_CH    = 6'(NUM_CH - 1);
    localparam logic [31:0]   MAGIC0     = 32'h2702_1942;
    localparam logic [31:0]   MAGIC1     = 32'hC691_1999;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sr;
    logic [SYNC_STAGES-1:0] cs_sr;
    logic [SYNC_STAGES-1:0] miso_sr;
    logic                   sclk_prev;
    logic                   cs_prev;
    logic                   sclk_s;
    logic                   cs_s;
    logic                   miso_s;
    logic                   sclk_rise;
    logic                   cs_fall;
    logic                   cs_rise;

    assign sclk_s = sclk_sr[SYNC_STAGES-1];
    assign cs_s   = cs_sr[SYNC_STAGES-1];
    assign miso_s = miso_sr[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sr   <= '0;
            cs_sr     <= '0;
            miso_sr   <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b0;
        end else begin
            sclk_sr[0] <= SCLK;
            cs_sr[0]   <= CS;
            miso_sr[0] <= MISO;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sclk_sr[i] <= sclk_sr[i-1];
                cs_sr[i]   <= cs_sr[i-1];
                miso_sr[i] <= miso_sr[i-1];
            end
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_prev;
    assign cs_fall   = ~cs_s & cs_prev;
    assign cs_rise   = cs_s & ~cs_prev;

    // ------------------------------------------------------------------
    // Deserializer: one word per CS window
    // ------------------------------------------------------------------
    // win_open masks the CS rise seen when the synchronizers leave reset
    // (they reset to 0 while CS idles high), so no phantom word appears.
    logic        win_open;
    logic [15:0] shreg;
    logic [4:0]  bit_cnt;
    logic [5:0]  ch_lat;
    logic [31:0] ts_lat;
    logic        wd_vld;
    logic [15:0] wd_data;
    logic [5:0]  wd_ch;
    logic [31:0] wd_ts;
    logic        word_done;
    logic        short_evt;

    assign word_done = cs_rise & win_open;
    assign short_evt = word_done & (bit_cnt != 5'd16);

    always_ff @(posedge clk) begin
        if (reset) begin
            win_open  <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= '0;
            ch_lat    <= '0;
            ts_lat    <= '0;
            wd_vld    <= 1'b0;
            wd_data   <= '0;
            wd_ch     <= '0;
            wd_ts     <= '0;
            err_short <= 1'b0;
        end else begin
            wd_vld <= 1'b0;
            if (cs_fall) begin
                win_open <= 1'b1;
                shreg    <= '0;
                bit_cnt  <= '0;
                ch_lat   <= channel;
                ts_lat   <= timestamp;
            end else if (word_done) begin
                win_open <= 1'b0;
                wd_vld   <= 1'b1;
                wd_data  <= (bit_cnt == 5'd16) ? shreg : 16'h0000;
                wd_ch    <= ch_lat;
                wd_ts    <= ts_lat;
            end else if (sclk_rise && !cs_s && win_open) begin
                shreg <= {shreg[14:0], miso_s};
                // saturate so an overlong window cannot wrap back to 16
                if (bit_cnt != 5'h1f) begin
                    bit_cnt <= bit_cnt + 5'd1;
                end
            end
            if (short_evt) begin
                err_short <= 1'b1;
            end else if (clear_errors) begin
                err_short <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Packer FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        PAD
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  hdr_idx_q, hdr_idx_d;
    logic [6:0]  wr_cnt_q, wr_cnt_d;
    logic [5:0]  exp_q, exp_d;
    logic [15:0] low_q, low_d;
    logic [31:0] ts_q, ts_d;
    logic        pend_vld_q, pend_vld_d;
    logic        pend_last_q, pend_last_d;
    logic [31:0] pend_data_q, pend_data_d;
    logic        rp_vld_q, rp_vld_d;
    logic [15:0] rp_data_q, rp_data_d;
    logic [31:0] rp_ts_q, rp_ts_d;

    logic        in_vld;
    logic [5:0]  in_ch;
    logic [15:0] in_data;
    logic [31:0] in_ts;
    logic [31:0] hdr_word;
    logic        push;
    logic [31:0] push_data;
    logic        push_last;
    logic        pop;
    logic        frame_inc;
    logic        drop_inc;
    logic        seq_evt;
    logic [CW-1:0] count;
    logic [CW-1:0] space;

    assign space = DEPTH_C - count;

    // A channel-0 word that broke a frame is replayed once PAD finishes.
    always_comb begin
        in_vld  = wd_vld;
        in_ch   = wd_ch;
        in_data = wd_data;
        in_ts   = wd_ts;
        if (rp_vld_q) begin
            in_vld  = 1'b1;
            in_ch   = 6'd0;
            in_data = rp_data_q;
            in_ts   = rp_ts_q;
        end
    end

    always_comb begin
        hdr_word = ts_q;
`ifdef FRAME_MAGIC_EN
        unique case (hdr_idx_q)
            2'd0:    hdr_word = MAGIC0;
            2'd1:    hdr_word = MAGIC1;
            default: hdr_word = ts_q;
        endcase
`endif
    end

    always_comb begin
        state_d     = state_q;
        hdr_idx_d   = hdr_idx_q;
        wr_cnt_d    = wr_cnt_q;
        exp_d       = exp_q;
        low_d       = low_q;
        ts_d        = ts_q;
        pend_vld_d  = pend_vld_q;
        pend_last_d = pend_last_q;
        pend_data_d = pend_data_q;
        rp_vld_d    = rp_vld_q;
        rp_data_d   = rp_data_q;
        rp_ts_d     = rp_ts_q;
        push        = 1'b0;
        push_data   = '0;
        push_last   = 1'b0;
        frame_inc   = 1'b0;
        drop_inc    = 1'b0;
        seq_evt     = 1'b0;

        unique case (state_q)
            IDLE: begin
                rp_vld_d = 1'b0;
                if (in_vld && in_ch == 6'd0) begin
                    // reserve a whole frame up front so pushes never overflow
                    if (space >= FRAME_C) begin
                        state_d    = COLLECT;
                        hdr_idx_d  = 2'd0;
                        wr_cnt_d   = 7'd0;
                        exp_d      = 6'd1;
                        low_d      = in_data;
                        ts_d       = in_ts;
                        pend_vld_d = 1'b0;
                        if (LAST_CH == 6'd0) begin
                            pend_vld_d  = 1'b1;
                            pend_last_d = 1'b1;
                            pend_data_d = {16'h0000, in_data};
                        end
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
            end

            COLLECT: begin
                if (wd_vld) begin
                    if (wd_ch == exp_q) begin
                        exp_d = exp_q + 6'd1;
                        if (!exp_q[0]) begin
                            low_d = wd_data;
                            if (exp_q == LAST_CH) begin
                                pend_vld_d  = 1'b1;
                                pend_last_d = 1'b1;
                                pend_data_d = {16'h0000, wd_data};
                            end
                        end else begin
                            pend_vld_d  = 1'b1;
                            pend_last_d = (exp_q == LAST_CH);
                            pend_data_d = {wd_data, low_q};
                        end
                    end else begin
                        seq_evt    = 1'b1;
                        state_d    = PAD;
                        pend_vld_d = 1'b0;
                        rp_vld_d   = (wd_ch == 6'd0);
                        rp_data_d  = wd_data;
                        rp_ts_d    = wd_ts;
                    end
                end else if (hdr_idx_q < HDR_C) begin
                    push      = 1'b1;
                    push_data = hdr_word;
                    hdr_idx_d = hdr_idx_q + 2'd1;
                    wr_cnt_d  = wr_cnt_q + 7'd1;
                end else if (pend_vld_q) begin
                    push       = 1'b1;
                    push_data  = pend_data_q;
                    push_last  = pend_last_q;
                    pend_vld_d = 1'b0;
                    wr_cnt_d   = wr_cnt_q + 7'd1;
                    if (pend_last_q) begin
                        frame_inc = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end

            PAD: begin
                push      = 1'b1;
                push_data = '0;
                push_last = (wr_cnt_q == FRAME_LAST);
                wr_cnt_d  = wr_cnt_q + 7'd1;
                if (wr_cnt_q == FRAME_LAST) begin
                    frame_inc = 1'b1;
                    state_d   = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            hdr_idx_q   <= '0;
            wr_cnt_q    <= '0;
            exp_q       <= '0;
            low_q       <= '0;
            ts_q        <= '0;
            pend_vld_q  <= 1'b0;
            pend_last_q <= 1'b0;
            pend_data_q <= '0;
            rp_vld_q    <= 1'b0;
            rp_data_q   <= '0;
            rp_ts_q     <= '0;
            frame_count <= '0;
            drop_count  <= '0;
            err_seq     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_idx_q   <= hdr_idx_d;
            wr_cnt_q    <= wr_cnt_d;
            exp_q       <= exp_d;
            low_q       <= low_d;
            ts_q        <= ts_d;
            pend_vld_q  <= pend_vld_d;
            pend_last_q <= pend_last_d;
            pend_data_q <= pend_data_d;
            rp_vld_q    <= rp_vld_d;
            rp_data_q   <= rp_data_d;
            rp_ts_q     <= rp_ts_d;
            if (frame_inc) begin
                frame_count <= frame_count + 32'd1;
            end
            if (drop_inc && drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
            if (seq_evt) begin
                err_seq <= 1'b1;
            end else if (clear_errors) begin
                err_seq <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO (first-word fall-through, tlast stored per entry)
    // ------------------------------------------------------------------
    logic [32:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign m_tvalid = (count != '0);
    assign pop      = m_tvalid & m_tready;
    assign m_tdata  = m_tvalid ? mem[rd_ptr][31:0] : 32'h0;
    assign m_tlast  = m_tvalid & mem[rd_ptr][32];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {push_last, push_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_miso_frame_packer.sv
// tb_miso_frame_packer: directed + randomized bench for miso_frame_packer.
// Drives SPI windows, predicts FIFO contents with a word-level frame model.

`timescale 1ns/1ps

module tb_miso_frame_packer;

    localparam int NUM_CH     = 35;
    localparam int FIFO_DEPTH = 64;
`ifdef FRAME_MAGIC_EN
    localparam int HDR = 3;
`else
    localparam int HDR = 1;
`endif
    localparam int FW = HDR + (NUM_CH + 1) / 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        SCLK = 1'b0;
    logic        CS = 1'b1;
    logic        MISO = 1'b0;
    logic [5:0]  channel = '0;
    logic [31:0] timestamp = '0;
    logic        clear_errors = 1'b0;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;
    logic [31:0] frame_count;
    logic [15:0] drop_count;
    logic        err_short;
    logic        err_seq;

    miso_frame_packer #(
        .NUM_CH(NUM_CH),
        .FIFO_DEPTH(FIFO_DEPTH),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .SCLK(SCLK),
        .CS(CS),
        .MISO(MISO),
        .channel(channel),
        .timestamp(timestamp),
        .clear_errors(clear_errors),
        .m_tdata(m_tdata),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .m_tlast(m_tlast),
        .frame_count(frame_count),
        .drop_count(drop_count),
        .err_short(err_short),
        .err_seq(err_seq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic [32:0] exp_q[$];
    logic [15:0] samp[$];
    bit          in_frame = 0;
    int          m_frames = 0;
    int          m_drops = 0;
    bit          m_eshort = 0;
    bit          m_eseq = 0;
    int          n_last = 0;
    bit          done = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void mpush(input logic [31:0] d, input bit last);
        exp_q.push_back({last, d});
    endfunction

    function automatic void model_start(input logic [15:0] v, input logic [31:0] ts);
        if (FIFO_DEPTH - exp_q.size() >= FW) begin
`ifdef FRAME_MAGIC_EN
            mpush(32'h2702_1942, 0);
            mpush(32'hC691_1999, 0);
`endif
            mpush(ts, 0);
            samp.delete();
            samp.push_back(v);
            in_frame = 1;
            if (NUM_CH == 1) begin
                mpush({16'h0, v}, 1);
                m_frames++;
                in_frame = 0;
            end
        end else if (m_drops < 65535) begin
            m_drops++;
        end
    endfunction

    function automatic void model_word(input int ch, input logic [15:0] v,
                                       input logic [31:0] ts);
        int n;
        int written;
        if (!in_frame) begin
            if (ch == 0) model_start(v, ts);
        end else if (ch == samp.size()) begin
            samp.push_back(v);
            n = samp.size();
            if (n % 2 == 0) mpush({v, samp[n-2]}, n == NUM_CH);
            else if (n == NUM_CH) mpush({16'h0, v}, 1);
            if (n == NUM_CH) begin
                m_frames++;
                in_frame = 0;
            end
        end else begin
            // broken frame: completed pairs already out, rest zero-filled
            m_eseq = 1;
            written = HDR + samp.size() / 2;
            for (int i = written; i < FW; i++) mpush(32'h0, i == FW - 1);
            m_frames++;
            in_frame = 0;
            if (ch == 0) model_start(v, ts);
        end
    endfunction

    // output monitor: compares every accepted word, checks stall stability
    logic [32:0] stall_word;
    bit          stalled = 0;
    always @(negedge clk) begin
        logic [32:0] e;
        if (reset) begin
            stalled = 0;
        end else begin
            if (stalled) begin
                check("stall_valid", m_tvalid, 1);
                check("stall_data", {m_tlast, m_tdata}, stall_word);
            end
            if (m_tvalid && m_tready) begin
                check("word_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("word", {m_tlast, m_tdata}, e);
                end
                if (m_tlast) n_last++;
                stalled = 0;
            end else if (m_tvalid) begin
                stalled = 1;
                stall_word = {m_tlast, m_tdata};
            end else begin
                stalled = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_word(input int ch, input logic [15:0] v, input int nbits);
        tick(1);
        channel = 6'(ch);
        CS = 1'b0;
        tick(3);
        for (int i = 0; i < nbits; i++) begin
            MISO = v[15-i];
            SCLK = 1'b0;
            tick(2);
            SCLK = 1'b1;
            tick(2);
        end
        SCLK = 1'b0;
        tick(2);
        CS = 1'b1;
        model_word(ch, (nbits == 16) ? v : 16'h0, timestamp);
        if (nbits != 16) m_eshort = 1;
        tick(4);
    endtask

    task automatic send_ts(input logic [31:0] ts, input bit rnd, input int short_ch);
        timestamp = ts;
        for (int c = 0; c < NUM_CH; c++) begin
            send_word(c, rnd ? 16'($urandom) : 16'(16'h1000 + c),
                      (c == short_ch) ? 15 : 16);
        end
    endtask

    task automatic wait_drain(input bit rnd);
        int t = 0;
        while ((exp_q.size() != 0 || m_tvalid) && t < 5000) begin
            if (rnd) m_tready = 1'($urandom_range(0, 1));
            tick(1);
            t++;
        end
        m_tready = 1'b1;
        check("drain_in_time", t < 5000, 1);
        tick(3);
    endtask

    task automatic pulse_clear();
        clear_errors = 1'b1;
        tick(1);
        clear_errors = 1'b0;
        m_eshort = 0;
        m_eseq = 0;
        tick(1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        exp_q.delete();
        samp.delete();
        in_frame = 0;
        m_frames = 0;
        m_drops = 0;
        m_eshort = 0;
        m_eseq = 0;
        tick(4);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_frames"}, frame_count, 32'(m_frames));
        check({tag, "_drops"}, drop_count, 16'(m_drops));
        check({tag, "_err_short"}, err_short, m_eshort);
        check({tag, "_err_seq"}, err_seq, m_eseq);
    endtask

    initial begin
        int lasts0;

        // reset state
        tick(3);
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_tlast", m_tlast, 0);
        check_state("rst");
        do_reset();
        check("post_rst_tvalid", m_tvalid, 0);

        // directed timestep: channel n = 0x1000+n, timestamp 5
        lasts0 = n_last;
        send_ts(32'd5, 0, -1);
        wait_drain(0);
        check_state("t1");
        check("t1_tlasts", n_last - lasts0, 1);

        // short window on channel 3
        send_ts(32'h0000_1234, 1, 3);
        wait_drain(0);
        check_state("t2");
        pulse_clear();
        check_state("t2_clear");

        // sequence 0,1,2 then a fresh 0: pad first, restart on second
        timestamp = 32'd6;
        send_word(0, 16'hAAAA, 16);
        send_word(1, 16'hBBBB, 16);
        send_word(2, 16'hCCCC, 16);
        send_ts(32'd7, 1, -1);
        wait_drain(0);
        check_state("t3");
        pulse_clear();
        check_state("t3_clear");

        // backpressure: 3 frames fit, 4th dropped
        m_tready = 1'b0;
        for (int k = 0; k < 4; k++) send_ts(32'(100 + k), 1, -1);
        tick(4);
        check_state("t4");
        check("t4_drop_one", drop_count, 1);
        check("t4_tvalid", m_tvalid, 1);
        check("t4_queued", exp_q.size(), 3 * FW);
        lasts0 = n_last;
        wait_drain(1);
        check("t4_tlasts", n_last - lasts0, 3);

        // reset mid-frame after channel 10
        m_tready = 1'b0;
        timestamp = 32'd200;
        for (int c = 0; c <= 10; c++) send_word(c, 16'($urandom), 16);
        check("t5_pre_tvalid", m_tvalid, 1);
        do_reset();
        check("t5_tvalid", m_tvalid, 0);
        check_state("t5");
        m_tready = 1'b1;
        send_ts(32'd201, 1, -1);
        wait_drain(0);
        check_state("t5_after");

        // random data with random backpressure while sending
        for (int k = 0; k < 2; k++) begin
            done = 0;
            fork
                begin
                    send_ts($urandom, 1, -1);
                    done = 1;
                end
                begin
                    while (!done) begin
                        m_tready = 1'($urandom_range(0, 1));
                        tick(1);
                    end
                end
            join
            wait_drain(1);
        end
        check_state("rnd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/miso_frame_packer.md
Name: miso_frame_packer

Overview:
- Downstream stage of the Intan SPI master (the block producing SCLK, CS, channel, timestamp).
- Deserializes MISO into 16-bit words per CS window and tags each word with the channel driven during that window.
- Packs one timestep's NUM_CH samples plus a timestamp header into a 32-bit frame.
- Buffers frames in an internal FIFO and presents them on an AXI-Stream-style master for the DMA path.

Parameters:
- NUM_CH, 35, channels per timestep (32 amplifier + 3 aux); legal range 1..64.
- FIFO_DEPTH, 64, output FIFO depth in 32-bit words; power of 2 and >= FRAME_WORDS.
- SYNC_STAGES, 2, register stages applied identically to MISO, SCLK and CS before edge detection.

Ports:
- clk  in  1  system clock, same domain as the SPI master.
- reset  in  1  synchronous, active-high reset.
- SCLK  in  1  SPI clock from the SPI master.
- CS  in  1  active-low chip select from the SPI master.
- MISO  in  1  serial data from the headstage.
- channel  in  6  channel index of the current CS window.
- timestamp  in  32  timestep counter from the SPI master.
- clear_errors  in  1  one-cycle pulse; clears err_short and err_seq.
- m_tdata  out  32  frame word.
- m_tvalid  out  1  m_tdata valid.
- m_tready  in  1  downstream accept.
- m_tlast  out  1  high on the final word of a frame.
- frame_count  out  32  frames fully written to the FIFO.
- drop_count  out  16  frames discarded for lack of space; saturates at 0xFFFF.
- err_short  out  1  sticky: a CS window closed with a bit count other than 16.
- err_seq  out  1  sticky: channel sequence broken mid-frame.

Behaviour:
- Reset values: all outputs 0; FIFO empty; FSM in IDLE; synchronizer registers 0. Reset asserted at any point flushes the FIFO and discards any in-progress frame.
- Sampling:
  - SCLK, CS and MISO pass through SYNC_STAGES flops.
  - On a synced SCLK rising edge while synced CS = 0, shift synced MISO in MSB-first; a 5-bit bit count increments.
  - On a synced CS falling edge, clear the shift register and bit count, and latch channel and timestamp.
- Word complete: on a synced CS rising edge.
  - If bit count == 16: the word is valid.
  - Otherwise: set err_short and substitute 0x0000.
  - Either way the word proceeds to the packer one cycle later.
- Frame layout, FRAME_WORDS = 1 + ceil(NUM_CH/2) (19 at default):
  - Word 0: timestamp latched with the channel-0 word.
  - Words 1..: sample pairs, with channel 2k in [15:0] and channel 2k+1 in [31:16].
  - Odd NUM_CH: upper half of the last word is 0x0000.
- Packer FSM (IDLE, COLLECT, PAD):
  - IDLE, word with channel == 0 arrives: check free space >= FRAME_WORDS. If yes, write the timestamp word, hold the sample in the low half, set expected channel = 1, go to COLLECT. If no, increment drop_count and stay in IDLE, ignoring words until the next channel 0.
  - IDLE, word with channel != 0: discard it.
  - COLLECT, word with channel == expected: place it in the low or high half, writing to the FIFO when the high half fills. At channel NUM_CH-1, write the final word with tlast, increment frame_count, return to IDLE.
  - COLLECT, channel != expected: set err_seq and go to PAD.
  - PAD: write zero words until FRAME_WORDS have been written, the last with tlast. Increment frame_count. If the offending word was channel 0, start a new frame (same space check); otherwise return to IDLE.
  - At most one FIFO write per cycle. Words arrive at least 16 SCLK periods apart, so PAD always completes before the next word.
- FIFO:
  - First-word fall-through; tlast is stored per entry.
  - m_tvalid = not empty. A pop happens when m_tvalid && m_tready.
  - A simultaneous push and pop at full is legal, because space is reserved at frame start.
  - Pushes never overflow.
  - m_tdata is stable while m_tvalid is high and m_tready is low.
- Counters and flags:
  - frame_count wraps at 2^32.
  - If clear_errors coincides with a new error event, the error wins and the flag stays 1.

Optional Feature:
- Macro: FRAME_MAGIC_EN.
- Defined: each frame is prefixed by two words, 0x27021942 then 0xC6911999, before the timestamp. FRAME_WORDS increases by 2, and the space check and PAD count use the larger value.
- Undefined: no magic words, and the layout is exactly as above.

Test Plan:
- NUM_CH=35, m_tready=1, MISO pattern gives channel n = 0x1000+n, timestamp=5 -> 19 words: 0x00000005, 0x10011000, ..., 0x00001022 with tlast on word 18; frame_count=1.
- CS window with 15 SCLK edges on channel 3 -> err_short=1, that half-word = 0x0000, frame still 19 words; clear_errors pulse -> err_short=0.
- Channel sequence 0,1,2,0 -> err_seq=1; first frame padded to 19 words with zeros and tlast; second frame starts at the second channel 0.
- m_tready=0 across 4 timesteps, FIFO_DEPTH=64 -> 3 frames stored (57 words), 4th dropped, drop_count=1; release m_tready -> 57 words drain, 3 tlasts, data stable during stalls.
- Reset pulsed mid-frame (after channel 10) -> m_tvalid=0, FIFO empty, counters 0; the next channel-0 word starts a clean frame.
- FRAME_MAGIC_EN defined -> each frame is 21 words beginning 0x27021942, 0xC6911999, timestamp.
